peripheral_display_ctrl: RTL and testbench



---
 rtl/peripheral_display_ctrl.sv | 132 +++++++++++++
 tb/tb_peripheral_display_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_display_ctrl.sv
// 4-digit 7-segment display controller: sequential double-dabble BCD conversion
// or fixed text load, time-multiplexed through one shared decoder.
module peripheral_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [3:0]  dig_code,
  output logic        dig_ext,
  output logic [3:0]  an
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t           state;
  logic [15:0]      mag;
  logic [19:0]      bcd;
  logic [3:0]       iter;
  logic             neg;
  logic [3:0][3:0]  disp_code;
  logic [3:0]       disp_ext;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       scan_idx;
  logic [1:0]       next_idx;
  logic [19:0]      bcd_adj;
  logic [35:0]      dd_shift;
  logic [1:0]       msd;
  logic             out_of_range;
  logic [3:0][3:0]  fmt_code;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the magnitude in.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    dd_shift = {bcd_adj, mag} << 1;
  end

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd = 2'(i);
    end
    out_of_range = neg ? (bcd[19:12] != 8'd0) : (bcd[19:16] != 4'd0);
    fmt_code = {4{4'hF}};
    if (out_of_range) begin
      fmt_code = {4{4'hB}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) <= msd) fmt_code[i] = bcd[i*4 +: 4];
      end
      // A negative in-range value has at most 3 digits, so msd+1 never wraps.
      if (neg) fmt_code[msd + 2'd1] = 4'hB;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      iter      <= '0;
      neg       <= 1'b0;
      disp_code <= {4{4'hF}};
      disp_ext  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (we) begin
            if (wdata[31]) begin
              disp_code <= {4'hF, 4'h0, 4'h1, 4'h2};
              disp_ext  <= 4'b0111;
            end else begin
              neg   <= wdata[15];
              mag   <= wdata[15] ? (~wdata[15:0] + 16'd1) : wdata[15:0];
              bcd   <= '0;
              iter  <= '0;
              state <= CONV;
              busy  <= 1'b1;
            end
          end
        end
        CONV: begin
          bcd  <= dd_shift[35:16];
          mag  <= dd_shift[15:0];
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= LOAD;
        end
        LOAD: begin
          disp_code <= fmt_code;
          disp_ext  <= '0;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign next_idx = scan_idx + 2'd1;

  // Free-running digit scan, independent of writes; outputs change only on the wrap edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
      an       <= 4'b1110;
      dig_code <= 4'hF;
      dig_ext  <= 1'b0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      scan_idx <= next_idx;
      an       <= ~(4'b0001 << next_idx);
      dig_code <= disp_code[next_idx];
      dig_ext  <= disp_ext[next_idx];
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_peripheral_display_ctrl.sv
// Scoreboard bench for peripheral_display_ctrl: expected displays are queued on write,
// and a monitor reassembles the 4 scanned digits after each display update.
module tb_peripheral_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam logic [19:0] TEXT_EXP = {4'b0111, 16'hF012};
  localparam logic [19:0] BLANK_EXP = {4'b0000, 16'hFFFF};

  logic        clk;
  logic        nreset;
  logic        we;
  logic [31:0] wdata;
  logic        busy;
  logic [3:0]  dig_code;
  logic        dig_ext;
  logic [3:0]  an;

  int total;
  int bad;
  int done_cnt;
  logic text_pending;
  logic [19:0] exp_q[$];

  peripheral_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .nreset(nreset),
    .we(we),
    .wdata(wdata),
    .busy(busy),
    .dig_code(dig_code),
    .dig_ext(dig_ext),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference display: decimal digits right-aligned, sign just left of them, {ext[3:0], codes}.
  function automatic logic [19:0] model_decimal(input logic [15:0] v);
    int sv, m, pos;
    logic [15:0] codes;
    sv = int'($signed(v));
    codes = 16'hFFFF;
    if (sv > 9999 || sv < -999) begin
      codes = 16'hBBBB;
    end else begin
      m = (sv < 0) ? -sv : sv;
      pos = 0;
      do begin
        codes[pos*4 +: 4] = 4'(m % 10);
        m = m / 10;
        pos++;
      end while (m != 0);
      if (sv < 0) codes[pos*4 +: 4] = 4'hB;
    end
    return {4'b0000, codes};
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (nreset && we && wdata[31] && !busy) text_pending = 1'b1;
  end

  // Monitor: a falling busy or an accepted text write means the display changed.
  initial begin : monitor
    logic prev_busy;
    logic [3:0] ref_an;
    logic [19:0] got;
    logic [19:0] exp;
    int idx;
    int waited;
    prev_busy = 1'b0;
    text_pending = 1'b0;
    forever begin
      @(negedge clk);
      if ((prev_busy && !busy) || text_pending) begin
        text_pending = 1'b0;
        got = '0;
        ref_an = an;
        for (int s = 0; s < 4; s++) begin
          waited = 0;
          while (an == ref_an && waited < 40) begin
            @(negedge clk);
            waited++;
          end
          check_output("scan_advance", {31'b0, an != ref_an}, 32'd1);
          ref_an = an;
          case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
          endcase
          check_output("an_onehot", {31'b0, idx >= 0}, 32'd1);
          if (idx >= 0) begin
            got[idx*4 +: 4] = dig_code;
            got[16 + idx] = dig_ext;
          end
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_update: got=%h expected=none", got);
        end else begin
          exp = exp_q.pop_front();
          check_output("display", {12'b0, got}, {12'b0, exp});
        end
        done_cnt++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int target);
    int w;
    w = 0;
    while (done_cnt < target && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_output("monitor_done", done_cnt, target);
  endtask

  task automatic apply_stimulus(input logic [31:0] w);
    int busy_cycles;
    int target;
    target = done_cnt + 1;
    if (w[31]) exp_q.push_back(TEXT_EXP);
    else exp_q.push_back(model_decimal(w[15:0]));
    @(negedge clk);
    we = 1'b1;
    wdata = w;
    @(negedge clk);
    we = 1'b0;
    busy_cycles = 0;
    if (w[31]) begin
      check_output("text_busy", {31'b0, busy}, 32'd0);
    end else begin
      while (busy && busy_cycles < 40) begin
        busy_cycles++;
        @(negedge clk);
      end
      check_output("busy_len", busy_cycles, 32'd17);
    end
    wait_done(target);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int target;
    int w;
    logic [15:0] v;
    logic [3:0] exp_an;
    total = 0;
    bad = 0;
    done_cnt = 0;
    nreset = 1'b0;
    we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_an", {28'b0, an}, 32'h0000000E);
    check_output("rst_code", {28'b0, dig_code}, 32'h0000000F);
    check_output("rst_ext", {31'b0, dig_ext}, 32'd0);
    nreset = 1'b1;

    // Blank scan sequence after reset release.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check_output("scan_an", {28'b0, an}, {28'b0, exp_an});
      check_output("scan_code", {28'b0, dig_code}, 32'h0000000F);
      check_output("scan_ext", {31'b0, dig_ext}, 32'd0);
      check_output("scan_busy", {31'b0, busy}, 32'd0);
    end

    apply_stimulus(32'h0000_04D2);
    apply_stimulus(32'h0000_FFD3);
    apply_stimulus(32'h0000_0000);
    apply_stimulus(32'h0000_FC19);
    apply_stimulus(32'h0000_270F);
    apply_stimulus(32'h0000_2710);
    apply_stimulus(32'h0000_FC18);
    apply_stimulus(32'h0000_8000);
    apply_stimulus(32'h0000_FFFF);
    apply_stimulus(32'h8000_0000);
    apply_stimulus(32'h0000_0007);
    apply_stimulus(32'hFFFF_0064);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: v = 16'($urandom_range(0, 9999));
        1: v = 16'(-int'($urandom_range(1, 999)));
        2: v = 16'($urandom);
        default: v = 16'($urandom_range(0, 99));
      endcase
      if ($urandom_range(0, 7) == 0) apply_stimulus(32'h8000_0000 | 32'($urandom_range(0, 65535)));
      else apply_stimulus({16'($urandom), v} & 32'h7FFF_FFFF);
    end

    // A write arriving during a conversion is dropped.
    target = done_cnt + 1;
    exp_q.push_back(model_decimal(16'd42));
    @(negedge clk);
    we = 1'b1;
    wdata = 32'd42;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    we = 1'b1;
    wdata = 32'd7;
    @(negedge clk);
    we = 1'b0;
    w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_output("drop_busy_low", {31'b0, busy}, 32'd0);
    wait_done(target);

    // Reset in the middle of a conversion blanks everything at once.
    target = done_cnt + 1;
    exp_q.push_back(BLANK_EXP);
    @(negedge clk);
    we = 1'b1;
    wdata = 32'd99;
    @(negedge clk);
    we = 1'b0;
    repeat (8) @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_an", {28'b0, an}, 32'h0000000E);
    check_output("abort_code", {28'b0, dig_code}, 32'h0000000F);
    check_output("abort_ext", {31'b0, dig_ext}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    wait_done(target);

    repeat (5) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
